// File: rtl/data_memory_unit.sv
// Data-memory stage behind the ALU: byte/half/word loads and stores on a word-organised RAM,
// with a valid/ready request handshake, load extension and rejection of misaligned/illegal accesses.
module data_memory_unit #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DEPTH_WORDS = 2 ** (ADDR_WIDTH - 2)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  mem_write,
  input  logic [1:0]            mem_size,
  input  logic                  load_unsigned,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           write_data,
  output logic [31:0]           load_data,
  output logic                  load_valid,
  output logic                  store_done,
  output logic                  misaligned,
  output logic                  error_sticky
);

  localparam int IDX_W = ADDR_WIDTH - 2;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    READ = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t           state_r;
  logic [31:0]      mem_r [DEPTH_WORDS];
  logic [IDX_W-1:0] idx_r;
  logic [1:0]       lane_r;
  logic [1:0]       size_r;
  logic             unsigned_r;

  logic             accept_s;
  logic             legal_s;
  logic [3:0]       be_s;
  logic [31:0]      wdata_s;

  // Select the addressed lane(s) of a word and sign- or zero-extend to 32 bits.
  function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_BYTE: r = {{24{b[7] & ~uns}}, b};
      SIZE_HALF: r = {{16{h[15] & ~uns}}, h};
      default:   r = word;
    endcase
    return r;
  endfunction

  assign req_ready = (state_r == IDLE);
  assign accept_s  = req_valid & req_ready;

  // Alignment legality of the presented request.
  always_comb begin
    legal_s = 1'b0;
    case (mem_size)
      SIZE_BYTE: legal_s = 1'b1;
      SIZE_HALF: legal_s = ~address[0];
      SIZE_WORD: legal_s = (address[1:0] == 2'b00);
      default:   legal_s = 1'b0;
    endcase
  end

  // Byte enables and lane-replicated store data; replication puts the low bits on every lane.
  always_comb begin
    be_s    = 4'b0000;
    wdata_s = write_data;
    case (mem_size)
      SIZE_BYTE: begin
        be_s    = 4'b0001 << address[1:0];
        wdata_s = {4{write_data[7:0]}};
      end
      SIZE_HALF: begin
        if (address[1]) begin
          be_s = 4'b1100;
        end else begin
          be_s = 4'b0011;
        end
        wdata_s = {2{write_data[15:0]}};
      end
      SIZE_WORD: begin
        be_s    = 4'b1111;
        wdata_s = write_data;
      end
      default: begin
        be_s    = 4'b0000;
        wdata_s = write_data;
      end
    endcase
  end

  // RAM write port; the array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (accept_s && legal_s && mem_write) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem_r[address[ADDR_WIDTH-1:2]][i*8 +: 8] <= wdata_s[i*8 +: 8];
        end
      end
    end
  end

  // Request FSM and registered response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      idx_r        <= '0;
      lane_r       <= 2'b00;
      size_r       <= 2'b00;
      unsigned_r   <= 1'b0;
      load_data    <= 32'h0000_0000;
      load_valid   <= 1'b0;
      store_done   <= 1'b0;
      misaligned   <= 1'b0;
      error_sticky <= 1'b0;
    end else begin
      load_valid <= 1'b0;
      store_done <= 1'b0;
      misaligned <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            if (!legal_s) begin
              misaligned   <= 1'b1;
              error_sticky <= 1'b1;
            end else if (mem_write) begin
              store_done <= 1'b1;
            end else begin
              idx_r      <= address[ADDR_WIDTH-1:2];
              lane_r     <= address[1:0];
              size_r     <= mem_size;
              unsigned_r <= load_unsigned;
              state_r    <= READ;
            end
          end
        end
        // Array read happens here, after any store on the accept edge has landed.
        READ: begin
          load_data  <= extend_load(mem_r[idx_r], size_r, lane_r, unsigned_r);
          load_valid <= 1'b1;
          state_r    <= RESP;
        end
        RESP: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
